// File: rtl/lcd1604_responder.sv
// lcd1604_responder: HD44780-style 8-bit LCD device model.
// Optional event trace ports: define LCD_RESP_TRACE_EN.
module lcd1604_responder #(
  parameter int         CLK_HZ     = 50000000,
  parameter int         BUSY_SHORT = 2000,
  parameter int         BUSY_LONG  = 82000,
  parameter logic [7:0] FILL_CHAR  = 8'h20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_en,
  input  logic [7:0] lcd_din,
  output logic [7:0] lcd_dout,
  output logic       lcd_dout_oe,
  output logic       busy,
  output logic [6:0] ac,
  output logic       display_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       inc_mode,
  output logic       shift_mode,
  output logic       two_line,
  output logic       bus_8bit,
  output logic       font_5x10,
  input  logic [6:0] mon_addr,
  output logic [7:0] mon_data,
  output logic       err_busy_wr,
  output logic       err_addr
`ifdef LCD_RESP_TRACE_EN
  ,
  output logic       evt_valid,
  output logic       evt_rs,
  output logic [7:0] evt_byte
`endif
);

  localparam int CNT_MAX =
    (BUSY_LONG > BUSY_SHORT) ? BUSY_LONG : BUSY_SHORT;
  // A non-positive clock rate falls back to a full-width counter.
  localparam int CW =
    (CLK_HZ > 0) ? $clog2(CNT_MAX + 1) : 32;

  typedef enum logic [1:0] {
    S_FILL,
    S_IDLE,
    S_BUSY
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [6:0]      fill_idx;
  logic            fill_long;
  logic            cgram_sel;

  logic            en_s1, en_s2, en_d;
  logic            rs_s1, rs_s2, rs_d;
  logic            rw_s1, rw_s2, rw_d;
  logic [7:0]      din_s1, din_s2, din_d;

  logic [7:0]      ddram [80];
  logic            mem_we;
  logic [6:0]      mem_waddr;
  logic [7:0]      mem_wdata;

  logic            txn;
  logic            wr_txn;
  logic            rd_txn;
  logic [6:0]      cur_idx;
  logic [6:0]      ac_next;
  logic [7:0]      rd_byte;

  logic is_dd, is_cg, is_fn, is_sh;
  logic is_dc, is_em, is_home, is_clr;

  function automatic logic [6:0] ac_step(
    input logic [6:0] a,
    input logic       up,
    input logic       two,
    input logic       cg
  );
    logic [6:0] r;
    r = a;
    if (cg) begin
      r = {1'b0, up ? a[5:0] + 6'd1
                    : a[5:0] - 6'd1};
    end else if (two) begin
      if (up)
        r = (a == 7'h27) ? 7'h40 :
            (a == 7'h67) ? 7'h00 : a + 7'd1;
      else
        r = (a == 7'h00) ? 7'h67 :
            (a == 7'h40) ? 7'h27 : a - 7'd1;
    end else begin
      if (up)
        r = (a >= 7'h4F) ? 7'h00 : a + 7'd1;
      else
        r = (a == 7'h00) ? 7'h4F : a - 7'd1;
    end
    return r;
  endfunction

  function automatic logic ac_valid(
    input logic [6:0] a,
    input logic       two
  );
    if (two)
      return (a <= 7'h27) ||
             (a >= 7'h40 && a <= 7'h67);
    return a <= 7'h4F;
  endfunction

  assign txn    = en_d & ~en_s2;
  assign wr_txn = txn & ~rw_d;
  assign rd_txn = txn & rw_d;

  assign cur_idx = (ac >= 7'h40) ? ac - 7'd24 : ac;
  assign ac_next = ac_step(ac, inc_mode,
                           two_line, cgram_sel);
  assign rd_byte = (cur_idx < 7'd80) ?
                   ddram[cur_idx] : 8'h00;

  assign is_dd   = din_d[7];
  assign is_cg   = din_d[7:6] == 2'b01;
  assign is_fn   = din_d[7:5] == 3'b001;
  assign is_sh   = din_d[7:4] == 4'b0001;
  assign is_dc   = din_d[7:3] == 5'b00001;
  assign is_em   = din_d[7:2] == 6'b000001;
  assign is_home = din_d[7:1] == 7'b0000001;
  assign is_clr  = din_d == 8'h01;

  // Two-flop synchronizers plus one history stage for edge detect.
  always_ff @(posedge clk) begin
    if (!reset) begin
      en_s1  <= 1'b0; en_s2  <= 1'b0; en_d  <= 1'b0;
      rs_s1  <= 1'b0; rs_s2  <= 1'b0; rs_d  <= 1'b0;
      rw_s1  <= 1'b0; rw_s2  <= 1'b0; rw_d  <= 1'b0;
      din_s1 <= 8'h00; din_s2 <= 8'h00; din_d <= 8'h00;
    end else begin
      en_s1  <= lcd_en;  en_s2  <= en_s1;  en_d  <= en_s2;
      rs_s1  <= lcd_rs;  rs_s2  <= rs_s1;  rs_d  <= rs_s2;
      rw_s1  <= lcd_rw;  rw_s2  <= rw_s1;  rw_d  <= rw_s2;
      din_s1 <= lcd_din; din_s2 <= din_s1; din_d <= din_s2;
    end
  end

  // Select the single DDRAM write port source: fill or data write.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = fill_idx;
    mem_wdata = FILL_CHAR;
    if (reset && state == S_FILL) begin
      mem_we = 1'b1;
    end else if (reset && state == S_IDLE &&
                 wr_txn && rs_d && !cgram_sel &&
                 cur_idx < 7'd80) begin
      mem_we    = 1'b1;
      mem_waddr = cur_idx;
      mem_wdata = din_d;
    end
  end

  // DDRAM storage; contents are defined by the fill after reset.
  always_ff @(posedge clk) begin
    if (mem_we)
      ddram[mem_waddr] <= mem_wdata;
  end

  // Main FSM: fill, command decode, busy timing and flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_FILL;
      cnt         <= '0;
      fill_idx    <= 7'd0;
      fill_long   <= 1'b0;
      busy        <= 1'b1;
      ac          <= 7'd0;
      cgram_sel   <= 1'b0;
      display_on  <= 1'b0;
      cursor_on   <= 1'b0;
      blink_on    <= 1'b0;
      inc_mode    <= 1'b1;
      shift_mode  <= 1'b0;
      two_line    <= 1'b0;
      bus_8bit    <= 1'b1;
      font_5x10   <= 1'b0;
      err_busy_wr <= 1'b0;
      err_addr    <= 1'b0;
    end else begin
      err_busy_wr <= wr_txn && state != S_IDLE;
      unique case (state)
        S_FILL: begin
          if (fill_idx == 7'd79) begin
            fill_idx  <= 7'd0;
            fill_long <= 1'b0;
            if (fill_long) begin
              state <= S_BUSY;
              cnt   <= CW'(BUSY_LONG - 1);
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            fill_idx <= fill_idx + 7'd1;
          end
        end
        S_BUSY: begin
          if (cnt == '0) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_IDLE: begin
          if (wr_txn) begin
            state <= S_BUSY;
            busy  <= 1'b1;
            cnt   <= CW'(BUSY_SHORT - 1);
            if (rs_d) begin
              ac <= ac_next;
            end else begin
              unique case (1'b1)
                is_dd: begin
                  cgram_sel <= 1'b0;
                  if (ac_valid(din_d[6:0], two_line)) begin
                    ac <= din_d[6:0];
                  end else begin
                    ac       <= 7'd0;
                    err_addr <= 1'b1;
                  end
                end
                is_cg: begin
                  cgram_sel <= 1'b1;
                  ac        <= {1'b0, din_d[5:0]};
                end
                is_fn: begin
                  bus_8bit  <= din_d[4];
                  two_line  <= din_d[3];
                  font_5x10 <= din_d[2];
                end
                is_sh: begin
                  if (!din_d[3])
                    ac <= ac_step(ac, din_d[2],
                                  two_line, cgram_sel);
                end
                is_dc: begin
                  display_on <= din_d[2];
                  cursor_on  <= din_d[1];
                  blink_on   <= din_d[0];
                end
                is_em: begin
                  inc_mode   <= din_d[1];
                  shift_mode <= din_d[0];
                end
                is_home: begin
                  ac  <= 7'd0;
                  cnt <= CW'(BUSY_LONG - 1);
                end
                is_clr: begin
                  ac        <= 7'd0;
                  inc_mode  <= 1'b1;
                  err_addr  <= 1'b0;
                  state     <= S_FILL;
                  fill_idx  <= 7'd0;
                  fill_long <= 1'b1;
                end
                default: begin
                end
              endcase
            end
          end else if (rd_txn && rs_d) begin
            ac <= ac_next;
          end
        end
        default: begin
          state <= S_FILL;
        end
      endcase
    end
  end

  // Bus read path: status any time, data only when not busy.
  always_ff @(posedge clk) begin
    if (!reset) begin
      lcd_dout    <= 8'h00;
      lcd_dout_oe <= 1'b0;
    end else begin
      lcd_dout_oe <= en_s2 & rw_s2;
      if (en_s2 & rw_s2)
        lcd_dout <= rs_s2 ? (busy ? 8'h00 : rd_byte)
                          : {busy, ac};
      else
        lcd_dout <= 8'h00;
    end
  end

  // Monitor port; a same-cycle write shows up on the next read.
  always_ff @(posedge clk) begin
    if (!reset)
      mon_data <= 8'h00;
    else
      mon_data <= (mon_addr < 7'd80) ?
                  ddram[mon_addr] : 8'h00;
  end

`ifdef LCD_RESP_TRACE_EN
  // Report every accepted write for external scoreboards.
  always_ff @(posedge clk) begin
    if (!reset) begin
      evt_valid <= 1'b0;
      evt_rs    <= 1'b0;
      evt_byte  <= 8'h00;
    end else begin
      evt_valid <= wr_txn && state == S_IDLE;
      if (wr_txn && state == S_IDLE) begin
        evt_rs   <= rs_d;
        evt_byte <= din_d;
      end
    end
  end
`endif

endmodule
